// File: rtl/draw_board_ctrl_if.sv
// Signal bundle between the frame-sequencing controller and the board renderer.
// master is the controller side, slave is the datapath/RAM/requester side.
interface draw_board_ctrl_if;
    logic       start;
    logic [5:0] board_addr;
    logic [5:0] board_data;
    logic [5:0] draw_value;
    logic       write;
    logic       update_x_y;
    logic       busy;
    logic       done;

    modport master (
        input  start, board_data,
        output board_addr, draw_value, write, update_x_y, busy, done
    );

    modport slave (
        output start, board_data,
        input  board_addr, draw_value, write, update_x_y, busy, done
    );
endinterface

// File: rtl/draw_board_ctrl.sv
// Repaint sequencer: background fill, 64 board cells from RAM, optional turn indicator.
// Define DRAW_TURN_IND_EN to include the player-turn indicator phase.
module draw_board_ctrl #(
    parameter int BG_CYCLES   = 32768,
    parameter int CELL_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    draw_board_ctrl_if.master bus
);
    localparam int BG_W   = (BG_CYCLES > 1) ? $clog2(BG_CYCLES) : 1;
    localparam int CELL_W = (CELL_CYCLES > 1) ? $clog2(CELL_CYCLES) : 1;
    localparam logic [BG_W-1:0]   BG_LAST   = BG_W'(BG_CYCLES - 1);
    localparam logic [CELL_W-1:0] CELL_LAST = CELL_W'(CELL_CYCLES - 1);
    localparam logic [5:0] BG_CODE = 6'b011000;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BG    = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_CELL  = 3'd4;
    localparam logic [2:0] S_ADV   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd7;
`ifdef DRAW_TURN_IND_EN
    localparam logic [2:0] S_TURN  = 3'd6;
    localparam logic [5:0] TURN_CODE = 6'b011100;
`endif

    logic [2:0]        state_q, state_d;
    logic [BG_W-1:0]   bg_cnt_q, bg_cnt_d;
    logic [CELL_W-1:0] cell_cnt_q, cell_cnt_d;
    logic [5:0]        board_addr_q, board_addr_d;
    logic [5:0]        cell_val_q, cell_val_d;
    logic              pending_q, pending_d;
    logic [5:0]        draw_value_q, draw_value_d;
    logic              write_q, write_d;
    logic              update_x_y_q, update_x_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d      = state_q;
        bg_cnt_d     = bg_cnt_q;
        cell_cnt_d   = cell_cnt_q;
        board_addr_d = board_addr_q;
        cell_val_d   = cell_val_q;
        pending_d    = pending_q;

        // Requests arriving mid-frame collapse into a single follow-up repaint.
        if (state_q != S_IDLE && bus.start) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_BG;
                    board_addr_d = 6'd0;
                    bg_cnt_d     = '0;
                    cell_cnt_d   = '0;
                end
            end
            S_BG: begin
                if (bg_cnt_q == BG_LAST) begin
                    bg_cnt_d = '0;
                    state_d  = S_FETCH;
                end else begin
                    bg_cnt_d = bg_cnt_q + 1'b1;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                cell_val_d = bus.board_data;
                state_d    = S_CELL;
            end
            S_CELL: begin
                if (cell_cnt_q == CELL_LAST) begin
                    cell_cnt_d = '0;
                    state_d    = S_ADV;
                end else begin
                    cell_cnt_d = cell_cnt_q + 1'b1;
                end
            end
            S_ADV: begin
                board_addr_d = board_addr_q + 6'd1;
                if (board_addr_q == 6'd63) begin
`ifdef DRAW_TURN_IND_EN
                    state_d = S_TURN;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_FETCH;
                end
            end
`ifdef DRAW_TURN_IND_EN
            S_TURN: begin
                if (cell_cnt_q == CELL_LAST) begin
                    cell_cnt_d = '0;
                    state_d    = S_DONE;
                end else begin
                    cell_cnt_d = cell_cnt_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                pending_d = 1'b0;
                if (pending_q || bus.start) begin
                    state_d      = S_BG;
                    board_addr_d = 6'd0;
                    bg_cnt_d     = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        draw_value_d = 6'd0;
        write_d      = 1'b0;
        update_x_y_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        case (state_d)
            S_BG: begin
                draw_value_d = BG_CODE;
                write_d      = 1'b1;
            end
            S_CELL: begin
                draw_value_d = cell_val_d;
                write_d      = 1'b1;
            end
`ifdef DRAW_TURN_IND_EN
            S_TURN: begin
                draw_value_d = TURN_CODE;
                write_d      = 1'b1;
            end
`endif
            S_ADV:   update_x_y_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bg_cnt_q     <= '0;
            cell_cnt_q   <= '0;
            board_addr_q <= 6'd0;
            cell_val_q   <= 6'd0;
            pending_q    <= 1'b0;
            draw_value_q <= 6'd0;
            write_q      <= 1'b0;
            update_x_y_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bg_cnt_q     <= bg_cnt_d;
            cell_cnt_q   <= cell_cnt_d;
            board_addr_q <= board_addr_d;
            cell_val_q   <= cell_val_d;
            pending_q    <= pending_d;
            draw_value_q <= draw_value_d;
            write_q      <= write_d;
            update_x_y_q <= update_x_y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.board_addr = board_addr_q;
    assign bus.draw_value = draw_value_q;
    assign bus.write      = write_q;
    assign bus.update_x_y = update_x_y_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_draw_board_ctrl.sv
// Directed bench for draw_board_ctrl with shortened phase lengths and a registered-read RAM model.
module tb_draw_board_ctrl;
    localparam int BG    = 40;
    localparam int CELL  = 6;
    localparam int PER   = CELL + 3;
`ifdef DRAW_TURN_IND_EN
    localparam int FRAME = BG + 64 * PER + CELL + 1;
`else
    localparam int FRAME = BG + 64 * PER + 1;
`endif

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   done_total;

    draw_board_ctrl_if bus ();

    draw_board_ctrl #(
        .BG_CYCLES   (BG),
        .CELL_CYCLES (CELL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] ram_word(input logic [5:0] a);
        return {a[0], a[4:0]};
    endfunction

    always @(posedge clk) bus.board_data <= ram_word(bus.board_addr);

    // Expected {busy, done, write, update_x_y, draw_value, board_addr} at cycle i of a frame.
    function automatic logic [15:0] exp_vec(input int i);
        logic [5:0] a;
        logic [5:0] dv;
        logic       w;
        logic       u;
        logic       d;
        int         j;
        int         k;
        a = 6'd0; dv = 6'd0; w = 1'b0; u = 1'b0; d = 1'b0;
        if (i < BG) begin
            w = 1'b1; dv = 6'h18;
        end else if (i < BG + 64 * PER) begin
            j = i - BG;
            a = 6'(j / PER);
            k = j % PER;
            if (k >= 2 && k < CELL + 2) begin
                w = 1'b1; dv = ram_word(a);
            end else if (k == PER - 1) begin
                u = 1'b1;
            end
        end
`ifdef DRAW_TURN_IND_EN
        else if (i < BG + 64 * PER + CELL) begin
            w = 1'b1; dv = 6'h1C;
        end
`endif
        else begin
            d = 1'b1;
        end
        return {1'b1, d, w, u, dv, a};
    endfunction

    function automatic logic [15:0] cur_vec();
        return {bus.busy, bus.done, bus.write, bus.update_x_y, bus.draw_value, bus.board_addr};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"}, 16'(bus.board_addr), 16'd0);
        check({tag, "_dv"},   16'(bus.draw_value), 16'd0);
        check({tag, "_wr"},   16'(bus.write),      16'd0);
        check({tag, "_uxy"},  16'(bus.update_x_y), 16'd0);
        check({tag, "_busy"}, 16'(bus.busy),       16'd0);
        check({tag, "_done"}, 16'(bus.done),       16'd0);
    endtask

    // Walks one frame cycle by cycle; start is pulsed after sampling at cycles p0/p1/p2.
    task automatic run_frame(input int p0, input int p1, input int p2, input string tag);
        int ux_cnt;
        int ovl;
        int dn;
        ux_cnt = 0; ovl = 0; dn = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            tests++;
            assert (cur_vec() === exp_vec(i)) else begin
                fails++;
                $error("FAIL %s[%0d]: got %h expected %h", tag, i, cur_vec(), exp_vec(i));
            end
            if (bus.update_x_y) ux_cnt++;
            if (bus.update_x_y && bus.write) ovl++;
            if (bus.done) dn++;
            bus.start = (i == p0) || (i == p1) || (i == p2);
        end
        check({tag, "_uxy_count"}, 16'(ux_cnt), 16'd64);
        check({tag, "_overlap"},   16'(ovl),    16'd0);
        check({tag, "_done_count"}, 16'(dn),    16'd1);
        check({tag, "_end_addr"},  16'(bus.board_addr), 16'd0);
        done_total += dn;
        $display("[TB] %s: %0d cycles, %0d update pulses, %0d done", tag, FRAME, ux_cnt, dn);
    endtask

    initial begin
        int stray;
        tests = 0; fails = 0; done_total = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle0");

        // Three requests during BG yield one extra frame; a request in DONE yields a third.
        bus.start = 1'b1;
        run_frame(3, 7, 12, "frame1");
        run_frame(-1, -1, FRAME - 1, "frame2");
        run_frame(-1, -1, -1, "frame3");
        @(negedge clk);
        check_idle("after3");
        check("done_total", 16'(done_total), 16'd3);

        // Reset mid-cell at address 17, with a pending request that must be dropped.
        bus.start = 1'b1;
        for (int i = 0; i <= BG + 17 * PER + 4; i++) begin
            @(negedge clk);
            check("partial", cur_vec(), exp_vec(i));
            bus.start = (i == 5);
        end
        check("rst_at_addr", 16'(bus.board_addr), 16'd17);
        reset = 1'b1;
        @(negedge clk);
        check_idle("midrst");
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.write) stray++;
        end
        check("post_rst_quiet", 16'(stray), 16'd0);

        bus.start = 1'b1;
        run_frame(-1, -1, -1, "frame4");
        @(negedge clk);
        check_idle("after4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
